ssm_hp_scheduler: RTL and testbench

SSM_HP_SCHEDULER -- requirements
Module: ssm_hp_scheduler

---
 rtl/ssm_hp_scheduler.sv | 171 +++++++++++++++++
 tb/tb_ssm_hp_scheduler.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/ssm_hp_scheduler.sv
// ssm_hp_scheduler: walks the (head, p, state-tile) space for an SSM core
// and routes each returned group result to address h*P+p via a tag FIFO.
module ssm_hp_scheduler #(
    parameter int DW        = 16,
    parameter int H         = 24,
    parameter int P         = 64,
    parameter int N_TOTAL   = 128,
    parameter int N_TILE    = 16,
    parameter int H_TILE    = 1,
    parameter int P_TILE    = 1,
    parameter int TAG_DEPTH = 16,
    localparam int TILES  = (N_TOTAL + N_TILE - 1) / N_TILE,
    localparam int GROUPS = H * P,
    localparam int AW     = (GROUPS > 1) ? $clog2(GROUPS) : 1,
    localparam int TW     = ($clog2(TILES * N_TILE + 1) > $clog2(TILES) + 1)
                          ? $clog2(TILES * N_TILE + 1) : $clog2(TILES) + 1,
    localparam int HW     = (H > 1) ? $clog2(H) : 1,
    localparam int PW     = (P > 1) ? $clog2(P) : 1,
    localparam int OW     = $clog2(TAG_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          tile_valid_o,
    input  logic          tile_ready_i,
    output logic [HW-1:0] tile_h_o,
    output logic [PW-1:0] tile_p_o,
    output logic [TW-1:0] tile_nbase_o,
    output logic          tile_first_o,
    output logic          tile_last_o,
    input  logic          y_valid_i,
    input  logic [DW-1:0] y_data_i,
    output logic          wr_en_o,
    output logic [AW-1:0] wr_addr_o,
    output logic [DW-1:0] wr_data_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [OW-1:0] outstanding_o,
    output logic          err_underflow_o
);
    localparam int CW  = $clog2(H + P + H_TILE + P_TILE) + 2;
    localparam int TCW = $clog2(TILES + 1) + 1;
    localparam int FW  = $clog2(TAG_DEPTH);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [CW-1:0]  h_blk, p_blk, h_rel, p_rel;
    logic [CW-1:0]  h_blk_n, p_blk_n, h_rel_n, p_rel_n;
    logic [CW-1:0]  h_abs, p_abs;
    logic [TCW-1:0] t;
    logic           last_group;
    logic [AW-1:0]  tag_mem [TAG_DEPTH];
    logic [FW-1:0]  wptr, rptr;
    logic [OW-1:0]  count;
    logic [31:0]    h_w, p_w;
    logic [AW-1:0]  tag;
    logic           t_first, t_last, full, xfer, push, pop, underflow, start_acc;

    assign h_abs     = h_blk + h_rel;
    assign p_abs     = p_blk + p_rel;
    assign h_w       = 32'(h_abs);
    assign p_w       = 32'(p_abs);
    assign tag       = AW'(h_w * 32'(P) + p_w);
    assign t_first   = (t == '0);
    assign t_last    = (t == TCW'(TILES - 1));
    assign full      = (count == OW'(TAG_DEPTH));
    assign start_acc = start_i && (state == IDLE || state == DONE);
    assign push      = xfer && t_last;
    assign pop       = y_valid_i && (count != '0);
    assign underflow = y_valid_i && (count == '0);

    // only a group's first tile waits for a free tag slot
    assign tile_valid_o = (state == ISSUE) && !(t_first && full);
    assign xfer         = tile_valid_o && tile_ready_i;
    assign tile_h_o     = HW'(h_abs);
    assign tile_p_o     = PW'(p_abs);
    assign tile_nbase_o = TW'(t) * TW'(N_TILE);
    assign tile_first_o = (state == ISSUE) && t_first;
    assign tile_last_o  = (state == ISSUE) && t_last;
    assign busy_o        = (state == ISSUE) || (state == DRAIN);
    assign done_o        = (state == DONE);
    assign outstanding_o = count;

    // jump straight to the next in-range (h, p) so skipped slots cost no cycle
    always_comb begin
        h_blk_n    = h_blk;
        p_blk_n    = p_blk;
        h_rel_n    = h_rel;
        p_rel_n    = p_rel;
        last_group = 1'b0;
        if ((p_rel + CW'(1) < CW'(P_TILE)) && (p_abs + CW'(1) < CW'(P))) begin
            p_rel_n = p_rel + CW'(1);
        end else if ((h_rel + CW'(1) < CW'(H_TILE)) && (h_abs + CW'(1) < CW'(H))) begin
            p_rel_n = '0;
            h_rel_n = h_rel + CW'(1);
        end else if (p_blk + CW'(P_TILE) < CW'(P)) begin
            p_rel_n = '0;
            h_rel_n = '0;
            p_blk_n = p_blk + CW'(P_TILE);
        end else if (h_blk + CW'(H_TILE) < CW'(H)) begin
            p_rel_n = '0;
            h_rel_n = '0;
            p_blk_n = '0;
            h_blk_n = h_blk + CW'(H_TILE);
        end else begin
            last_group = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start_i) state_nxt = ISSUE;
            ISSUE: if (push && last_group) state_nxt = DRAIN;
            DRAIN: if (count == '0) state_nxt = DONE;
            DONE:  if (start_i) state_nxt = ISSUE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_blk <= '0; p_blk <= '0; h_rel <= '0; p_rel <= '0; t <= '0;
        end else if (start_acc) begin
            h_blk <= '0; p_blk <= '0; h_rel <= '0; p_rel <= '0; t <= '0;
        end else if (xfer) begin
            if (t_last) begin
                t     <= '0;
                h_blk <= h_blk_n;
                p_blk <= p_blk_n;
                h_rel <= h_rel_n;
                p_rel <= p_rel_n;
            end else begin
                t <= t + TCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) tag_mem[wptr] <= tag;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr            <= '0;
            rptr            <= '0;
            count           <= '0;
            wr_en_o         <= 1'b0;
            wr_addr_o       <= '0;
            wr_data_o       <= '0;
            err_underflow_o <= 1'b0;
        end else begin
            if (push) wptr <= wptr + FW'(1);
            if (pop)  rptr <= rptr + FW'(1);
            if (push && !pop)      count <= count + OW'(1);
            else if (pop && !push) count <= count - OW'(1);
            wr_en_o <= pop;
            if (pop) begin
                wr_addr_o <= tag_mem[rptr];
                wr_data_o <= y_data_i;
            end
            if (underflow)      err_underflow_o <= 1'b1;
            else if (start_acc) err_underflow_o <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ssm_hp_scheduler.sv
// tb_ssm_hp_scheduler: random traffic against a queue-based scan/tag model.
module tb_ssm_hp_scheduler;
    localparam int DW = 16, H = 3, P = 3, N_TOTAL = 32, N_TILE = 16;
    localparam int H_TILE = 2, P_TILE = 2, TAG_DEPTH = 4;
    localparam int TILES = (N_TOTAL + N_TILE - 1) / N_TILE;
    localparam int AW = $clog2(H * P);
    localparam int TW = ($clog2(TILES * N_TILE + 1) > $clog2(TILES) + 1)
                      ? $clog2(TILES * N_TILE + 1) : $clog2(TILES) + 1;
    localparam int HW = $clog2(H), PW = $clog2(P), OW = $clog2(TAG_DEPTH) + 1;

    logic clk = 1'b0, rst, start_i, tile_ready_i, y_valid_i;
    logic [DW-1:0] y_data_i;
    logic tile_valid_o, tile_first_o, tile_last_o, wr_en_o;
    logic busy_o, done_o, err_underflow_o;
    logic [HW-1:0] tile_h_o;
    logic [PW-1:0] tile_p_o;
    logic [TW-1:0] tile_nbase_o;
    logic [AW-1:0] wr_addr_o;
    logic [DW-1:0] wr_data_o;
    logic [OW-1:0] outstanding_o;

    ssm_hp_scheduler #(.DW(DW), .H(H), .P(P), .N_TOTAL(N_TOTAL), .N_TILE(N_TILE),
        .H_TILE(H_TILE), .P_TILE(P_TILE), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .tile_valid_o(tile_valid_o),
        .tile_ready_i(tile_ready_i), .tile_h_o(tile_h_o), .tile_p_o(tile_p_o),
        .tile_nbase_o(tile_nbase_o), .tile_first_o(tile_first_o),
        .tile_last_o(tile_last_o), .y_valid_i(y_valid_i), .y_data_i(y_data_i),
        .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
        .busy_o(busy_o), .done_o(done_o), .outstanding_o(outstanding_o),
        .err_underflow_o(err_underflow_o));

    always #5 clk = ~clk;

    typedef struct {int h; int p; int nb; bit first; bit last;} tile_t;
    typedef enum {M_IDLE, M_ISSUE, M_DRAIN, M_DONE} ph_t;

    tile_t tq[$];
    int    tagq[$];
    ph_t   phase = M_IDLE;
    bit    m_err = 0, m_wr = 0;
    int    m_addr = 0, m_data = 0;
    int    n_tests = 0, n_fail = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic build_scan();
        tile_t e;
        tq.delete();
        for (int hb = 0; hb < H; hb += H_TILE)
            for (int pb = 0; pb < P; pb += P_TILE)
                for (int hr = 0; hr < H_TILE; hr++)
                    for (int pr = 0; pr < P_TILE; pr++)
                        if (hb + hr < H && pb + pr < P)
                            for (int t = 0; t < TILES; t++) begin
                                e.h = hb + hr; e.p = pb + pr; e.nb = t * N_TILE;
                                e.first = (t == 0); e.last = (t == TILES - 1);
                                tq.push_back(e);
                            end
    endtask

    task automatic step(input bit st, input bit rdy, input bit yv, input logic [DW-1:0] yd);
        tile_t e;
        bit    ev;
        int    sz;
        ph_t   ph0;
        start_i = st; tile_ready_i = rdy; y_valid_i = yv; y_data_i = yd;
        #1;
        sz = tagq.size();
        ph0 = phase;
        check("busy", busy_o, ph0 == M_ISSUE || ph0 == M_DRAIN);
        check("done", done_o, ph0 == M_DONE);
        check("outstanding", outstanding_o, sz);
        check("err_underflow", err_underflow_o, m_err);
        check("wr_en", wr_en_o, m_wr);
        if (m_wr) begin
            check("wr_addr", wr_addr_o, m_addr);
            check("wr_data", wr_data_o, m_data);
        end
        ev = (ph0 == M_ISSUE) && tq.size() > 0 && !(tq[0].first && sz == TAG_DEPTH);
        check("tile_valid", tile_valid_o, ev);
        if (ev) begin
            check("tile_h", tile_h_o, tq[0].h);
            check("tile_p", tile_p_o, tq[0].p);
            check("tile_nbase", tile_nbase_o, tq[0].nb);
            check("tile_first", tile_first_o, tq[0].first);
            check("tile_last", tile_last_o, tq[0].last);
        end
        m_wr = 0;
        if (yv && sz > 0) begin
            m_wr = 1; m_addr = tagq.pop_front(); m_data = yd;
        end
        if (yv && sz == 0) m_err = 1;
        else if (st && (ph0 == M_IDLE || ph0 == M_DONE)) m_err = 0;
        if (ph0 == M_DRAIN && sz == 0) phase = M_DONE;
        if (ev && rdy) begin
            e = tq.pop_front();
            if (e.last) tagq.push_back(e.h * P + e.p);
            if (tq.size() == 0) phase = M_DRAIN;
        end
        if (st && (ph0 == M_IDLE || ph0 == M_DONE)) begin
            phase = M_ISSUE;
            build_scan();
        end
        @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctrl"}, {tile_valid_o, wr_en_o, busy_o, done_o, err_underflow_o,
                              outstanding_o, tile_first_o, tile_last_o}, 0);
        check({tag, "_data"}, {tile_h_o, tile_p_o, tile_nbase_o, wr_addr_o, wr_data_o}, 0);
    endtask

    task automatic mid_reset();
        rst = 1'b1;
        #1;
        check_all_zero("async_rst");
        tq.delete(); tagq.delete();
        phase = M_IDLE; m_err = 0; m_wr = 0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int yprob;
        rst = 1'b1; start_i = 0; tile_ready_i = 0; y_valid_i = 0; y_data_i = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        step(0, 0, 1, 16'h1234);
        step(0, 0, 0, 0);
        step(1, 1, 0, 0);
        for (int c = 0; c < 100 && tagq.size() < 3; c++) step(0, 1, 0, 0);
        check("reach_three", tagq.size(), 3);
        mid_reset();
        for (int c = 0; c < 5; c++) step(0, 1, 0, 0);
        for (int s = 0; s < 9; s++) begin
            yprob = (s % 3 == 0) ? 12 : (s % 3 == 1) ? 50 : 85;
            step(1, $urandom_range(0, 3) != 0, 0, 0);
            for (int c = 0; c < 3000 && phase != M_DONE; c++)
                step($urandom_range(0, 15) == 0, $urandom_range(0, 3) != 0,
                     $urandom_range(0, 99) < yprob, DW'($urandom));
            check("scan_complete", phase == M_DONE, 1);
            for (int c = 0; c < 4; c++)
                step(0, $urandom_range(0, 1), $urandom_range(0, 3) == 0, DW'($urandom));
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
